txtbuf_arbiter: RTL and testbench

// - Shares the single-port text-page RAM (txtbuf) between two requesters: the VDP character fetch
//   (video, default priority) and the CPU bus (reads and writes).
// - Registered request/ack handshake per requester. Registered RAM address, write-enable and data.
// - Starvation guard: the CPU is guaranteed a slot after MAX_WAIT cycles of waiting.
// - Address window check: out-of-window CPU accesses never reach the RAM.

---
 rtl/txtbuf_arbiter.sv | 158 +++++++++++++++
 tb/tb_txtbuf_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txtbuf_arbiter.sv
// txtbuf_arbiter: shares the single-port text-page RAM between the VDP
// character fetch (video, default priority) and the CPU bus.
// Optional build macro: TXTARB_STATS_EN adds the conf_cnt contention counter.
module txtbuf_arbiter #(
    parameter int unsigned          ADR_W    = 16,
    parameter int unsigned          DAT_W    = 8,
    parameter logic [ADR_W-1:0]     WIN_LO   = 16'h0400,
    parameter logic [ADR_W-1:0]     WIN_HI   = 16'h07F8,
    parameter int unsigned          MAX_WAIT = 4
) (
    input  logic             CLOCK_50,
    input  logic             res,
    input  logic             vid_req,
    input  logic [ADR_W-1:0] vid_adr,
    output logic             vid_ack,
    output logic             vid_valid,
    output logic [DAT_W-1:0] vid_q,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [DAT_W-1:0] cpu_d,
    output logic             cpu_ack,
    output logic             cpu_valid,
    output logic [DAT_W-1:0] cpu_q,
`ifdef TXTARB_STATS_EN
    output logic [15:0]      conf_cnt,
`endif
    output logic [ADR_W-1:0] ram_adr,
    output logic             ram_we,
    output logic [DAT_W-1:0] ram_d,
    input  logic [DAT_W-1:0] ram_q
);

    localparam int unsigned     WC_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_VID,
        GRANT_CPU
    } grant_t;

    grant_t          state;
    grant_t          state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            vid_mreq;
    logic            cpu_mreq;
    logic            cpu_in_win;

    // Read pipeline: s1 = ack cycle, s2 = RAM data cycle
    logic            cpu_rd_s1;
    logic            cpu_oow_s1;
    logic            vid_rd_s2;
    logic            cpu_rd_s2;
    logic            cpu_oow_s2;

    // Grant register: the state names whoever owns the RAM port this cycle
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            state <= GRANT_NONE;
        end else begin
            state <= state_nxt;
        end
    end

    // Masked requests, priority decision and ack decode
    always_comb begin
        vid_mreq   = vid_req && (state != GRANT_VID);
        cpu_mreq   = cpu_req && (state != GRANT_CPU);
        cpu_in_win = (cpu_adr >= WIN_LO) && (cpu_adr <= WIN_HI);
        state_nxt  = GRANT_NONE;
        if (vid_mreq && cpu_mreq) begin
            state_nxt = (wait_cnt == WC_MAX) ? GRANT_CPU : GRANT_VID;
        end else if (vid_mreq) begin
            state_nxt = GRANT_VID;
        end else if (cpu_mreq) begin
            state_nxt = GRANT_CPU;
        end
        vid_ack = (state == GRANT_VID);
        cpu_ack = (state == GRANT_CPU);
    end

    // CPU starvation counter: counts edges the CPU waited and lost
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            wait_cnt <= '0;
        end else if (cpu_mreq && (state_nxt != GRANT_CPU)) begin
            wait_cnt <= (wait_cnt == WC_MAX) ? WC_MAX : wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Registered RAM port; address and data hold while idle
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            ram_adr    <= '0;
            ram_we     <= 1'b0;
            ram_d      <= '0;
            cpu_rd_s1  <= 1'b0;
            cpu_oow_s1 <= 1'b0;
        end else begin
            cpu_rd_s1  <= (state_nxt == GRANT_CPU) && !cpu_we;
            cpu_oow_s1 <= !cpu_in_win;
            case (state_nxt)
                GRANT_VID: begin
                    ram_adr <= vid_adr;
                    ram_we  <= 1'b0;
                end
                GRANT_CPU: begin
                    ram_adr <= cpu_adr;
                    ram_d   <= cpu_d;
                    ram_we  <= cpu_we && cpu_in_win;
                end
                default: begin
                    ram_we  <= 1'b0;
                end
            endcase
        end
    end

    // Read-return pipeline: capture RAM data two cycles after the ack
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            vid_rd_s2  <= 1'b0;
            cpu_rd_s2  <= 1'b0;
            cpu_oow_s2 <= 1'b0;
            vid_valid  <= 1'b0;
            cpu_valid  <= 1'b0;
            vid_q      <= '0;
            cpu_q      <= '0;
        end else begin
            vid_rd_s2  <= (state == GRANT_VID);
            cpu_rd_s2  <= cpu_rd_s1;
            cpu_oow_s2 <= cpu_oow_s1;
            vid_valid  <= vid_rd_s2;
            cpu_valid  <= cpu_rd_s2;
            if (vid_rd_s2) begin
                vid_q <= ram_q;
            end
            if (cpu_rd_s2) begin
                cpu_q <= cpu_oow_s2 ? '0 : ram_q;
            end
        end
    end

`ifdef TXTARB_STATS_EN
    // Contention statistics: edges where both masked requests compete
    always_ff @(posedge CLOCK_50 or negedge res) begin
        if (!res) begin
            conf_cnt <= '0;
        end else if (vid_mreq && cpu_mreq) begin
            conf_cnt <= conf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_txtbuf_arbiter.sv
// Self-checking bench for txtbuf_arbiter: directed cases plus randomized
// traffic checked against a transaction-level reference model.
module tb_txtbuf_arbiter;

    localparam int unsigned MAX_WAIT = 4;

    logic        CLOCK_50 = 1'b0;
    logic        res = 1'b0;
    logic        vid_req = 1'b0;
    logic [15:0] vid_adr = '0;
    logic        vid_ack, vid_valid;
    logic [7:0]  vid_q;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_adr = '0;
    logic [7:0]  cpu_d = '0;
    logic        cpu_ack, cpu_valid;
    logic [7:0]  cpu_q;
    logic [15:0] ram_adr;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q = '0;
`ifdef TXTARB_STATS_EN
    logic [15:0] conf_cnt;
`endif

    txtbuf_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLOCK_50(CLOCK_50), .res(res),
        .vid_req(vid_req), .vid_adr(vid_adr), .vid_ack(vid_ack),
        .vid_valid(vid_valid), .vid_q(vid_q),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_d(cpu_d),
        .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .cpu_q(cpu_q),
`ifdef TXTARB_STATS_EN
        .conf_cnt(conf_cnt),
`endif
        .ram_adr(ram_adr), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous single-port RAM, read-before-write
    logic [7:0] ram [0:65535];
    always @(posedge CLOCK_50) begin
        if (ram_we) ram[ram_adr] <= ram_d;
        ram_q <= ram[ram_adr];
    end

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Reference model state
    typedef struct {
        int unsigned due;
        logic [7:0]  data;
    } rd_t;

    rd_t         vq[$];
    rd_t         cq[$];
    logic [7:0]  wr_mem [logic [15:0]];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned cpu_wait = 0;
    logic        exp_vack = 1'b0;
    logic        exp_cack = 1'b0;
    logic [15:0] last_adr = '0;
    logic [15:0] exp_conf = '0;

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        if (wr_mem.exists(a)) return wr_mem[a];
        return init_val(a);
    endfunction

    function automatic logic in_win(input logic [15:0] a);
        return (a >= 16'h0400) && (a <= 16'h07F8);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock: predict the grant from the requests present at the
    // edge, then check every DUT output against the model after the edge.
    task automatic tick();
        logic        mv, mc, nv, nc;
        logic [15:0] gv_adr, gc_adr;
        logic        gc_we;
        logic [7:0]  gc_d;
        logic        ev, ec;
        mv = vid_req && !exp_vack;
        mc = cpu_req && !exp_cack;
        nv = 1'b0;
        nc = 1'b0;
        if (mv && mc) begin
            if (cpu_wait == MAX_WAIT) nc = 1'b1;
            else nv = 1'b1;
        end else if (mv) nv = 1'b1;
        else if (mc) nc = 1'b1;
        if (mc && !nc) cpu_wait = (cpu_wait < MAX_WAIT) ? cpu_wait + 1 : MAX_WAIT;
        else cpu_wait = 0;
        if (mv && mc) exp_conf = exp_conf + 16'd1;
        gv_adr = vid_adr;
        gc_adr = cpu_adr;
        gc_we  = cpu_we;
        gc_d   = cpu_d;

        @(posedge CLOCK_50);
        #1;
        cyc++;
        exp_vack = nv;
        exp_cack = nc;
        check_eq("vid_ack", 32'(vid_ack), 32'(nv));
        check_eq("cpu_ack", 32'(cpu_ack), 32'(nc));
        if (nv) begin
            check_eq("vid_ram_adr", 32'(ram_adr), 32'(gv_adr));
            check_eq("vid_ram_we", 32'(ram_we), 32'd0);
            vq.push_back('{due: cyc + 2, data: ref_rd(gv_adr)});
            last_adr = gv_adr;
        end else if (nc) begin
            check_eq("cpu_ram_adr", 32'(ram_adr), 32'(gc_adr));
            check_eq("cpu_ram_we", 32'(ram_we), 32'(gc_we && in_win(gc_adr)));
            if (gc_we) begin
                check_eq("cpu_ram_d", 32'(ram_d), 32'(gc_d));
                if (in_win(gc_adr)) wr_mem[gc_adr] = gc_d;
            end else begin
                cq.push_back('{due: cyc + 2, data: in_win(gc_adr) ? ref_rd(gc_adr) : 8'h00});
            end
            last_adr = gc_adr;
        end else begin
            check_eq("idle_ram_we", 32'(ram_we), 32'd0);
            check_eq("idle_ram_adr", 32'(ram_adr), 32'(last_adr));
        end
        ev = (vq.size() > 0) && (vq[0].due == cyc);
        ec = (cq.size() > 0) && (cq[0].due == cyc);
        check_eq("vid_valid", 32'(vid_valid), 32'(ev));
        check_eq("cpu_valid", 32'(cpu_valid), 32'(ec));
        if (ev) begin
            check_eq("vid_q", 32'(vid_q), 32'(vq[0].data));
            void'(vq.pop_front());
        end
        if (ec) begin
            check_eq("cpu_q", 32'(cpu_q), 32'(cq[0].data));
            void'(cq.pop_front());
        end
`ifdef TXTARB_STATS_EN
        check_eq("conf_cnt", 32'(conf_cnt), 32'(exp_conf));
`endif
    endtask

    task automatic do_reset();
        res = 1'b0;
        vid_req = 1'b0;
        cpu_req = 1'b0;
        #1;
        check_eq("rst_vid_ack", 32'(vid_ack), 32'd0);
        check_eq("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        check_eq("rst_vid_valid", 32'(vid_valid), 32'd0);
        check_eq("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        check_eq("rst_vid_q", 32'(vid_q), 32'd0);
        check_eq("rst_cpu_q", 32'(cpu_q), 32'd0);
        check_eq("rst_ram_adr", 32'(ram_adr), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_ram_d", 32'(ram_d), 32'd0);
`ifdef TXTARB_STATS_EN
        check_eq("rst_conf_cnt", 32'(conf_cnt), 32'd0);
`endif
        vq.delete();
        cq.delete();
        exp_vack = 1'b0;
        exp_cack = 1'b0;
        cpu_wait = 0;
        exp_conf = '0;
        last_adr = '0;
        repeat (2) @(posedge CLOCK_50);
        #1 res = 1'b1;
    endtask

    // One CPU access, with a bounded wait for the ack and a drain for the data
    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d);
        logic got;
        got = 1'b0;
        cpu_req = 1'b1;
        cpu_we  = we;
        cpu_adr = a;
        cpu_d   = d;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (cpu_ack) got = 1'b1;
        end
        check_eq("cpu_ack_seen", 32'(got), 32'd1);
        cpu_req = 1'b0;
        repeat (3) tick();
    endtask

    function automatic logic [15:0] rnd_adr();
        case ($urandom_range(0, 7))
            0: return 16'h03FF;
            1: return 16'h0400;
            2: return 16'h07F8;
            3: return 16'h07F9;
            4: return 16'h0800;
            default: return 16'h05A0 + 16'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = init_val(16'(i));
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        int unsigned lat;

        do_reset();
        repeat (2) tick();

        // Video-only read of the window base
        vid_req = 1'b1;
        vid_adr = 16'h0400;
        tick();
        check_eq("vid_first_ack", 32'(vid_ack), 32'd1);
        vid_req = 1'b0;
        repeat (3) tick();

        // CPU write then read back inside the window
        cpu_access(1'b1, 16'h05A0, 8'hC1);
        cpu_access(1'b0, 16'h05A0, 8'h00);
        check_eq("cpu_readback", 32'(cpu_q), 32'h00C1);

        // Out-of-window write is dropped, read returns zero
        cpu_access(1'b1, 16'h0800, 8'h55);
        cpu_access(1'b0, 16'h0800, 8'h00);
        check_eq("oow_read_zero", 32'(cpu_q), 32'd0);

        // Contention: video keeps requesting, CPU held
        vid_req = 1'b1;
        vid_adr = 16'h0600;
        tick();
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 16'h0410;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            lat++;
            if (cpu_ack) got = 1'b1;
            else if (vid_ack) vid_adr = vid_adr + 16'd1;
        end
        check_eq("contend_cpu_lat", 32'(got && (lat <= 5)), 32'd1);
        cpu_req = 1'b0;
        tick();
        check_eq("contend_vid_next", 32'(vid_ack), 32'd1);
        vid_req = 1'b0;
        repeat (3) tick();

        // Randomized traffic from both requesters
        for (int i = 0; i < 3000; i++) begin
            if (!vid_req || vid_ack) begin
                vid_req = ($urandom_range(0, 99) < 60);
                vid_adr = rnd_adr();
            end
            if (!cpu_req || cpu_ack) begin
                cpu_req = ($urandom_range(0, 99) < 55);
                cpu_we  = 1'($urandom_range(0, 1));
                cpu_adr = rnd_adr();
                cpu_d   = 8'($urandom);
            end
            tick();
        end
        vid_req = 1'b0;
        cpu_req = 1'b0;
        repeat (4) tick();

        // Reset between cpu_ack and cpu_valid: the read must vanish
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 16'h0401;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (cpu_ack) got = 1'b1;
        end
        check_eq("midrd_ack_seen", 32'(got), 32'd1);
        do_reset();
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
